cnn_layer_seq: RTL and testbench



---
 rtl/cnn_pkg.sv | 36 +++
 rtl/cnn_layer_seq_watchdog.sv | 32 +++
 rtl/cnn_layer_seq.sv | 178 +++++++++++++++++
 tb/tb_cnn_layer_seq.sv | 360 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared types and helpers for the CNN layer sequencer.
package cnn_pkg;

    localparam int unsigned DEF_NUM_LAYERS = 4;
    localparam int unsigned DEF_TIMEOUT_W  = 16;
    localparam int unsigned MAX_LAYERS     = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH,
        S_ERR
    } seq_state_t;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
    } bit_sel_t;

    // Lowest set bit of mask at index >= from_idx; valid=0 when none exists.
    function automatic bit_sel_t next_set_bit(input logic [MAX_LAYERS-1:0] mask,
                                              input int unsigned           from_idx);
        bit_sel_t r;
        r.valid = 1'b0;
        r.idx   = '0;
        for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
            if (!r.valid && (i >= from_idx) && mask[i]) begin
                r.valid = 1'b1;
                r.idx   = 4'(i);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/cnn_layer_seq_watchdog.sv
// Per-layer watchdog: clearable, saturating cycle counter with limit compare.
// A limit of zero disables expiry.
module cnn_watchdog #(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [TIMEOUT_W-1:0] limit,
    output logic                 expire
);

    logic [TIMEOUT_W-1:0] count;

    // Count enabled cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + TIMEOUT_W'(1);
        end
    end

    // Expire in the cycle where the count reaches limit-1 (the limit-th counted cycle).
    always_comb begin
        expire = (limit != '0) && (count == (limit - TIMEOUT_W'(1)));
    end

endmodule

// File: rtl/cnn_layer_seq.sv
// CNN layer sequencer: launches enabled layer engines in index order with a
// one-cycle start pulse, waits for each done, supports a per-run skip mask,
// a watchdog timeout with sticky error capture, and abort.
// Optional build macro CNN_SEQ_PERF_EN adds the run_cycles busy-cycle counter.
module cnn_layer_seq
    import cnn_pkg::*;
#(
    parameter  int unsigned NUM_LAYERS = DEF_NUM_LAYERS,
    parameter  int unsigned TIMEOUT_W  = DEF_TIMEOUT_W,
    localparam int unsigned IDX_W      = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [NUM_LAYERS-1:0] layer_en_mask,
    input  logic [TIMEOUT_W-1:0]  timeout_limit,
    input  logic                  abort,
    output logic [NUM_LAYERS-1:0] layer_start,
    input  logic [NUM_LAYERS-1:0] layer_done,
    output logic                  busy,
    output logic [IDX_W-1:0]      cur_layer,
    output logic                  done,
    output logic                  error,
    output logic [IDX_W-1:0]      err_layer
`ifdef CNN_SEQ_PERF_EN
    ,
    output logic [31:0]           run_cycles
`endif
);

    seq_state_t              state_q, state_n;
    logic [IDX_W-1:0]        cur_q, cur_n;
    logic [IDX_W-1:0]        err_q, err_n;
    logic [NUM_LAYERS-1:0]   mask_q, mask_n;
    logic [TIMEOUT_W-1:0]    limit_q, limit_n;

    logic                    start_acc;
    logic                    wd_clr;
    logic                    wd_en;
    logic                    wd_expire;

    logic [MAX_LAYERS-1:0]   mask_in_ext;
    logic [MAX_LAYERS-1:0]   mask_run_ext;
    bit_sel_t                first_sel;
    bit_sel_t                next_sel;

    cnn_watchdog #(
        .TIMEOUT_W(TIMEOUT_W)
    ) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr   (wd_clr),
        .en    (wd_en),
        .limit (limit_q),
        .expire(wd_expire)
    );

    // Zero-extend the incoming and latched masks to the helper's fixed width.
    always_comb begin
        mask_in_ext                   = '0;
        mask_in_ext[NUM_LAYERS-1:0]   = layer_en_mask;
        mask_run_ext                  = '0;
        mask_run_ext[NUM_LAYERS-1:0]  = mask_q;
    end

    // Sequencer state, run configuration and error capture registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cur_q   <= '0;
            err_q   <= '0;
            mask_q  <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_n;
            cur_q   <= cur_n;
            err_q   <= err_n;
            mask_q  <= mask_n;
            limit_q <= limit_n;
        end
    end

    // Next-state logic: abort has priority over done, done over timeout.
    always_comb begin
        state_n   = state_q;
        cur_n     = cur_q;
        err_n     = err_q;
        mask_n    = mask_q;
        limit_n   = limit_q;
        start_acc = 1'b0;
        wd_clr    = 1'b0;
        wd_en     = 1'b0;
        first_sel = next_set_bit(mask_in_ext, 0);
        next_sel  = next_set_bit(mask_run_ext, 32'(cur_q) + 32'd1);

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                end
            end
            S_ERR: begin
                if (abort) begin
                    state_n = S_IDLE;
                    err_n   = '0;
                end else if (start) begin
                    start_acc = 1'b1;
                end
            end
            S_LAUNCH: begin
                wd_clr  = 1'b1;
                state_n = abort ? S_IDLE : S_WAIT;
            end
            S_WAIT: begin
                wd_en = 1'b1;
                if (abort) begin
                    state_n = S_IDLE;
                end else if (layer_done[cur_q]) begin
                    if (next_sel.valid) begin
                        cur_n   = IDX_W'(next_sel.idx);
                        state_n = S_LAUNCH;
                    end else begin
                        state_n = S_FINISH;
                    end
                end else if (wd_expire) begin
                    state_n = S_ERR;
                    err_n   = cur_q;
                end
            end
            S_FINISH: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        // An accepted start (from IDLE or ERR) latches the run configuration.
        if (start_acc) begin
            mask_n  = layer_en_mask;
            limit_n = timeout_limit;
            err_n   = '0;
            if (first_sel.valid) begin
                cur_n   = IDX_W'(first_sel.idx);
                state_n = S_LAUNCH;
            end else begin
                state_n = S_FINISH;
            end
        end
    end

    // Outputs decoded purely from registered state.
    always_comb begin
        layer_start = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            layer_start[i] = (state_q == S_LAUNCH) && (cur_q == IDX_W'(i));
        end
        busy      = (state_q == S_LAUNCH) || (state_q == S_WAIT);
        done      = (state_q == S_FINISH);
        error     = (state_q == S_ERR);
        cur_layer = cur_q;
        err_layer = err_q;
    end

`ifdef CNN_SEQ_PERF_EN
    // Busy-cycle counter for the current run; held after the run ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_cycles <= '0;
        end else if (start_acc) begin
            run_cycles <= '0;
        end else if (busy && (run_cycles != '1)) begin
            run_cycles <= run_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cnn_layer_seq.sv
// Scoreboard bench for cnn_layer_seq: the driver predicts output events and
// state snapshots per run; a monitor compares them as the DUT presents them.
module tb_cnn_layer_seq;

    localparam int NL   = 4;
    localparam int TW   = 16;
    localparam int NONE = 1 << 30;

    localparam int K_START = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    localparam int S_ZERO     = 0;
    localparam int S_ERRBIT   = 1;
    localparam int S_ERRLAYER = 2;
    localparam int S_BUSY     = 3;
    localparam int S_FLUSH    = 4;
    localparam int S_PERF     = 5;

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } item_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [NL-1:0] layer_en_mask = '0;
    logic [TW-1:0] timeout_limit = '0;
    logic [NL-1:0] layer_start;
    logic [NL-1:0] layer_done;
    logic          busy;
    logic [1:0]    cur_layer;
    logic          done;
    logic          error;
    logic [1:0]    err_layer;
`ifdef CNN_SEQ_PERF_EN
    logic [31:0]   run_cycles;
`endif

    logic [NL-1:0] resp_done  = '0;
    logic [NL-1:0] stray_done = '0;
    int            lat_cfg [NL];
    int            resp_cnt[NL];
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;
    item_t         ev_q[$];
    item_t         snap_q[$];
    int            last_end;
    int            last_perf;
    int            last_err_idx;
    logic          err_prev = 1'b0;

    cnn_layer_seq #(
        .NUM_LAYERS(NL),
        .TIMEOUT_W (TW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .layer_en_mask(layer_en_mask),
        .timeout_limit(timeout_limit),
        .abort        (abort),
        .layer_start  (layer_start),
        .layer_done   (layer_done),
        .busy         (busy),
        .cur_layer    (cur_layer),
        .done         (done),
        .error        (error),
        .err_layer    (err_layer)
`ifdef CNN_SEQ_PERF_EN
        ,
        .run_cycles   (run_cycles)
`endif
    );

    assign layer_done = resp_done | stray_done;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Layer engine model: done arrives lat_cfg[i] cycles after its start pulse (0 = never).
    initial begin
        for (int i = 0; i < NL; i++) begin
            resp_cnt[i] = 0;
            lat_cfg[i]  = 3;
        end
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NL; i++) begin
                if (resp_cnt[i] > 0) begin
                    resp_cnt[i] = resp_cnt[i] - 1;
                    resp_done[i] = (resp_cnt[i] == 0);
                end else begin
                    resp_done[i] = 1'b0;
                end
            end
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                if (layer_start[i]) resp_cnt[i] = lat_cfg[i];
            end
        end
    end

    // ---------------- monitor side ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic got_event(input int kind, input int idx);
        item_t e;
        if (ev_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event: got kind %0d idx %0d at cycle %0d, want none",
                     kind, idx, cyc);
        end else begin
            e = ev_q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_idx", idx, e.idx);
            chk("event_cycle", cyc, e.cyc);
        end
    endtask

    task automatic do_snap(input item_t s);
        case (s.kind)
            S_ZERO: begin
                chk("reset_outputs",
                    int'({layer_start, busy, done, error, cur_layer, err_layer}), 0);
`ifdef CNN_SEQ_PERF_EN
                chk("reset_run_cycles", int'(run_cycles), 0);
`endif
            end
            S_ERRBIT:   chk("error_flag", int'(error), s.idx);
            S_ERRLAYER: begin
                chk("error_held", int'(error), 1);
                chk("err_layer", int'(err_layer), s.idx);
            end
            S_BUSY:     chk("busy", int'(busy), s.idx);
            S_FLUSH: begin
                chk("pending_events", ev_q.size(), 0);
                ev_q.delete();
            end
            S_PERF: begin
`ifdef CNN_SEQ_PERF_EN
                chk("run_cycles", int'(run_cycles), s.idx);
`endif
            end
            default: ;
        endcase
    endtask

    // Monitor: turns DUT output activity into events and applies due snapshots.
    initial begin
        forever begin
            @(negedge clk);
            if (layer_start != '0) begin
                chk("start_onehot", $countones(layer_start), 1);
                for (int i = 0; i < NL; i++) begin
                    if (layer_start[i]) begin
                        got_event(K_START, i);
                        chk("cur_layer_at_start", int'(cur_layer), i);
                    end
                end
            end
            if (done) got_event(K_DONE, 0);
            if (error && !err_prev) got_event(K_ERR, int'(err_layer));
            err_prev = error;
            while (snap_q.size() > 0 && snap_q[0].cyc <= cyc) do_snap(snap_q.pop_front());
        end
    end

    // ---------------- driver side ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int tgt);
        while (cyc < tgt) step();
    endtask

    task automatic snap(input int kind, input int val, input int at);
        snap_q.push_back('{kind, val, at});
    endtask

    task automatic push_ev(input int kind, input int idx, input int at, input int cut);
        if (at <= cut) ev_q.push_back('{kind, idx, at});
    endtask

    task automatic set_lat(input int a, input int b, input int c, input int d);
        lat_cfg[0] = a;
        lat_cfg[1] = b;
        lat_cfg[2] = c;
        lat_cfg[3] = d;
    endtask

    // Issue a run and predict its events; anything after cycle 'cut' is cancelled.
    task automatic run(input logic [NL-1:0] m, input int lim, input int cut);
        int t;
        int c0;
        bit failed;
        layer_en_mask = m;
        timeout_limit = lim[TW-1:0];
        start         = 1'b1;
        c0            = cyc;
        t             = c0 + 1;
        failed        = 1'b0;
        last_err_idx  = -1;
        for (int i = 0; i < NL; i++) begin
            if (!failed && m[i]) begin
                push_ev(K_START, i, t, cut);
                if (lim != 0 && (lat_cfg[i] == 0 || lat_cfg[i] > lim)) begin
                    failed       = 1'b1;
                    last_err_idx = i;
                    t            = t + lim + 1;
                    push_ev(K_ERR, i, t, cut);
                end else begin
                    t = t + lat_cfg[i] + 1;
                end
            end
        end
        if (!failed) push_ev(K_DONE, 0, t, cut);
        last_end  = (t < cut) ? t : cut;
        last_perf = t - c0 - 1;
        step();
        start = 1'b0;
    endtask

    task automatic settle(input bit cut_run);
        wait_until(last_end + 2);
        snap(S_FLUSH, 0, cyc);
        snap(S_BUSY, 0, cyc);
        if (!cut_run && last_err_idx >= 0) begin
            snap(S_ERRLAYER, last_err_idx, cyc);
        end else begin
            snap(S_ERRBIT, 0, cyc);
        end
        if (!cut_run) snap(S_PERF, last_perf, cyc);
        step();
    endtask

    initial begin
        int c0;
        logic [NL-1:0] rm;
        int rl;

        rst = 1'b1;
        repeat (3) step();
        snap(S_ZERO, 0, cyc);
        rst = 1'b0;
        step();
        snap(S_ZERO, 0, cyc);
        step();

        // all layers, 3-cycle latency
        set_lat(3, 3, 3, 3);
        run(4'b1111, 0, NONE);
        settle(1'b0);

        // skip mask
        run(4'b1010, 0, NONE);
        settle(1'b0);

        // empty mask: straight to done, never busy
        run(4'b0000, 0, NONE);
        snap(S_BUSY, 0, cyc);
        settle(1'b0);

        // layer 2 never answers: timeout held, then cleared by a new start
        set_lat(3, 3, 0, 3);
        run(4'b1111, 8, NONE);
        settle(1'b0);
        repeat (5) step();
        snap(S_ERRLAYER, 2, cyc);
        set_lat(3, 3, 3, 3);
        run(4'b1111, 0, NONE);
        snap(S_ERRBIT, 0, cyc);
        settle(1'b0);

        // watchdog boundary: latency == limit passes, limit+1 times out
        set_lat(4, 4, 4, 4);
        run(4'b0011, 4, NONE);
        settle(1'b0);
        set_lat(4, 5, 4, 4);
        run(4'b0011, 4, NONE);
        settle(1'b0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        snap(S_ERRBIT, 0, cyc);
        snap(S_BUSY, 0, cyc);
        step();

        // abort in WAIT of layer 1 coinciding with its done; stray done and start while busy
        set_lat(3, 3, 3, 3);
        c0 = cyc;
        run(4'b1111, 0, c0 + 8);
        wait_until(c0 + 6);
        stray_done = 4'b0001;
        step();
        stray_done = '0;
        start = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b1;
        step();
        abort = 1'b0;
        settle(1'b1);

        // abort during the LAUNCH cycle of layer 1: that pulse still goes out
        c0 = cyc;
        run(4'b1111, 0, c0 + 5);
        wait_until(c0 + 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        settle(1'b1);

        // reset mid-WAIT
        c0 = cyc;
        run(4'b1111, 0, c0 + 3);
        wait_until(c0 + 3);
        rst = 1'b1;
        step();
        rst = 1'b0;
        snap(S_ZERO, 0, cyc);
        settle(1'b1);

        // randomized runs
        repeat (24) begin
            rm = NL'($urandom_range(0, 15));
            rl = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 8));
            for (int i = 0; i < NL; i++) lat_cfg[i] = int'($urandom_range(1, 10));
            run(rm, rl, NONE);
            settle(1'b0);
        end

        for (int k = 0; k < 100 && snap_q.size() != 0; k++) step();
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL sim_timeout: got no end of test, want completion");
        $fatal(1);
    end

endmodule
